// File: rtl/ot_pkg.sv
// Shared constants, state encoding and hue-range helper for the object tracker.
package ot_pkg;
  localparam int X_W_DEF     = 11;
  localparam int Y_W_DEF     = 10;
  localparam int MIN_PIX_DEF = 16;

  typedef logic [1:0] ot_state_t;
  localparam ot_state_t ST_IDLE    = 2'd0;
  localparam ot_state_t ST_WAIT_VS = 2'd1;
  localparam ot_state_t ST_ACTIVE  = 2'd2;

  // lo > hi describes a range that wraps through 255 -> 0.
  function automatic logic hue_match(input logic [7:0] hue, input logic [7:0] lo,
                                     input logic [7:0] hi);
    if (lo <= hi) return (hue >= lo) && (hue <= hi);
    else          return (hue >= lo) || (hue <= hi);
  endfunction
endpackage

// File: rtl/ot_bbox_acc.sv
// Bounding-box and matched-pixel accumulator; result is combinationally ready,
// zeroed when fewer than MIN_PIX pixels matched.
module ot_bbox_acc
  import ot_pkg::*;
#(
  parameter int MIN_PIX = MIN_PIX_DEF,
  parameter int X_W     = X_W_DEF,
  parameter int Y_W     = Y_W_DEF
) (
  input  logic           pclk,
  input  logic           rst,
  input  logic           clr,
  input  logic           upd,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  output logic           res_found,
  output logic [X_W-1:0] res_xmin,
  output logic [X_W-1:0] res_xmax,
  output logic [Y_W-1:0] res_ymin,
  output logic [Y_W-1:0] res_ymax
);
  logic [X_W-1:0] xmin_q, xmax_q;
  logic [Y_W-1:0] ymin_q, ymax_q;
  logic [15:0]    cnt_q;

  always_ff @(posedge pclk) begin
    if (rst || clr) begin
      xmin_q <= '1;
      xmax_q <= '0;
      ymin_q <= '1;
      ymax_q <= '0;
      cnt_q  <= '0;
    end else if (upd) begin
      if (x < xmin_q) xmin_q <= x;
      if (x > xmax_q) xmax_q <= x;
      if (y < ymin_q) ymin_q <= y;
      if (y > ymax_q) ymax_q <= y;
      if (cnt_q != 16'hffff) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign res_found = (32'(cnt_q) >= MIN_PIX);
  assign res_xmin  = res_found ? xmin_q : '0;
  assign res_xmax  = res_found ? xmax_q : '0;
  assign res_ymin  = res_found ? ymin_q : '0;
  assign res_ymax  = res_found ? ymax_q : '0;
endmodule

// File: rtl/ot_track_ctrl.sv
// Colour-target tracking controller: arms on start, accumulates a bounding box of
// hue-matched pixels per frame and publishes it at each frame-ending vsync edge.
module ot_track_ctrl
  import ot_pkg::*;
#(
  parameter int MIN_PIX = MIN_PIX_DEF,
  parameter int X_W     = X_W_DEF,
  parameter int Y_W     = Y_W_DEF
) (
  input  logic           pclk,
  input  logic           rst,
  input  logic           i_start,
  input  logic           i_stop,
  input  logic           i_vsync,
  input  logic           i_href,
  input  logic           i_data_en,
  input  logic [7:0]     i_hue,
  input  logic [7:0]     i_hue_lo,
  input  logic [7:0]     i_hue_hi,
  output logic           o_pipe_en,
  output logic           o_busy,
  output logic           o_box_valid,
  input  logic           i_box_ready,
  output logic           o_found,
  output logic [X_W-1:0] o_xmin,
  output logic [X_W-1:0] o_xmax,
  output logic [Y_W-1:0] o_ymin,
  output logic [Y_W-1:0] o_ymax,
  output logic [7:0]     o_frame_cnt,
  output logic           o_overrun
);
  ot_state_t      state, state_nx;
  logic           vs_d, href_d, stop_pend;
  logic           vs_rise, href_fall, stop_now, publish, frame_start, pix_match;
  logic [7:0]     lo_q, hi_q;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic           acc_found;
  logic [X_W-1:0] acc_xmin, acc_xmax;
  logic [Y_W-1:0] acc_ymin, acc_ymax;

  always_comb begin
    vs_rise   = i_vsync & ~vs_d;
    href_fall = href_d & ~i_href;
    stop_now  = stop_pend | i_stop;
    state_nx  = state;
    case (state)
      ST_IDLE:    if (i_start && !i_stop) state_nx = ST_WAIT_VS;
      ST_WAIT_VS: if (i_stop) state_nx = ST_IDLE;
                  else if (vs_rise) state_nx = ST_ACTIVE;
      ST_ACTIVE:  if (vs_rise && stop_now) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
    // Any rising edge that leaves us in ACTIVE opens a new frame.
    frame_start = vs_rise && (state_nx == ST_ACTIVE);
    publish     = vs_rise && (state == ST_ACTIVE);
    pix_match   = (state == ST_ACTIVE) && !vs_rise && i_data_en &&
                  hue_match(i_hue, lo_q, hi_q);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state     <= ST_IDLE;
      vs_d      <= 1'b0;
      href_d    <= 1'b0;
      stop_pend <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
    end else begin
      state  <= state_nx;
      vs_d   <= i_vsync;
      href_d <= i_href;
      if (state_nx != ST_ACTIVE) stop_pend <= 1'b0;
      else if (i_stop)           stop_pend <= 1'b1;
      if (frame_start) begin
        lo_q <= i_hue_lo;
        hi_q <= i_hue_hi;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      if (!i_href)                       x_q <= '0;
      else if (i_data_en && x_q != '1)   x_q <= x_q + X_W'(1);
      if (frame_start)                   y_q <= '0;
      else if (href_fall && y_q != '1)   y_q <= y_q + Y_W'(1);
    end
  end

  ot_bbox_acc #(
    .MIN_PIX (MIN_PIX),
    .X_W     (X_W),
    .Y_W     (Y_W)
  ) u_acc (
    .pclk      (pclk),
    .rst       (rst),
    .clr       (frame_start),
    .upd       (pix_match),
    .x         (x_q),
    .y         (y_q),
    .res_found (acc_found),
    .res_xmin  (acc_xmin),
    .res_xmax  (acc_xmax),
    .res_ymin  (acc_ymin),
    .res_ymax  (acc_ymax)
  );

  // A publish always wins over a same-cycle handshake so the new result stays valid.
  always_ff @(posedge pclk) begin
    if (rst) begin
      o_box_valid <= 1'b0;
      o_found     <= 1'b0;
      o_xmin      <= '0;
      o_xmax      <= '0;
      o_ymin      <= '0;
      o_ymax      <= '0;
      o_frame_cnt <= '0;
      o_overrun   <= 1'b0;
    end else if (publish) begin
      o_box_valid <= 1'b1;
      o_found     <= acc_found;
      o_xmin      <= acc_xmin;
      o_xmax      <= acc_xmax;
      o_ymin      <= acc_ymin;
      o_ymax      <= acc_ymax;
      o_frame_cnt <= o_frame_cnt + 8'd1;
      if (o_box_valid && !i_box_ready) o_overrun <= 1'b1;
    end else if (o_box_valid && i_box_ready) begin
      o_box_valid <= 1'b0;
    end
  end

  assign o_busy    = (state != ST_IDLE);
  assign o_pipe_en = (state == ST_WAIT_VS) || (state == ST_ACTIVE);
endmodule

// File: doc/ot_track_ctrl.md
OT_TRACK_CTRL -- requirements
Module: ot_track_ctrl

Interface
REQ-001 SHALL have parameter MIN_PIX, default 16: matched-pixel count at or above which a target is declared found.
REQ-002 SHALL have parameter X_W, default 11, and parameter Y_W, default 10: coordinate widths.
REQ-003 SHALL have ports (clock and reset first); reset is synchronous and active-high:
- pclk  in  1  pixel clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse; arms tracking.
- i_stop  in  1  one-cycle pulse; disarms tracking.
- i_vsync  in  1  frame sync from the hue pipeline; a rising edge marks a frame boundary.
- i_href  in  1  line valid from the hue pipeline.
- i_data_en  in  1  hue sample valid.
- i_hue  in  8  hue sample.
- i_hue_lo  in  8  match range low bound, inclusive.
- i_hue_hi  in  8  match range high bound, inclusive.
- o_pipe_en  out  1  enable to the capture/hue pipeline.
- o_busy  out  1  state is not IDLE.
- o_box_valid  out  1  result valid.
- i_box_ready  in  1  result consumed.
- o_found  out  1  target present in the reported frame.
- o_xmin, o_xmax  out  X_W  bounding box columns.
- o_ymin, o_ymax  out  Y_W  bounding box rows.
- o_frame_cnt  out  8  completed-frame count; wraps at 255->0.
- o_overrun  out  1  sticky flag: an unconsumed result was overwritten.

Function
REQ-004 SHALL implement a three-state FSM:
- IDLE -> WAIT_VS on i_start.
- WAIT_VS -> ACTIVE on a vsync rising edge.
- WAIT_VS -> IDLE on i_stop.
- ACTIVE -> ACTIVE on each vsync rising edge when no stop is pending (publish result, start new frame).
- ACTIVE -> IDLE on a vsync rising edge when a stop is pending (publish result).
REQ-005 SHALL detect the vsync rising edge as i_vsync=1 with the previous-cycle registered i_vsync=0.
REQ-006 SHALL latch i_stop during ACTIVE as stop-pending; the frame in progress SHALL complete and be reported. Stop-pending SHALL be cleared on entering IDLE.
REQ-007 SHALL give i_stop priority over i_start when both are asserted in the same cycle. i_start SHALL be ignored outside IDLE.
REQ-008 SHALL drive o_pipe_en=1 in WAIT_VS and ACTIVE, and 0 in IDLE.
REQ-009 SHALL latch i_hue_lo and i_hue_hi on every frame-start edge; changes mid-frame SHALL have no effect.
REQ-010 SHALL count a sample as a match when i_data_en=1 and the hue is in range:
- lo<=hi: lo<=hue<=hi.
- lo>hi (wrap-around range): hue>=lo or hue<=hi.
REQ-011 SHALL maintain the column counter x: incremented per i_data_en sample, zeroed while i_href=0, saturating at 2^X_W-1.
REQ-012 SHALL maintain the row counter y: incremented on each i_href falling edge, zeroed at frame start, saturating at 2^Y_W-1.
REQ-013 SHALL update the bounding box on each match: xmin/xmax/ymin/ymax track the min/max of the matched (x,y). At frame start, min values SHALL initialise to all-ones and max values to zero.
REQ-014 SHALL keep a 16-bit matched-pixel count, saturating, cleared at frame start.
REQ-015 SHALL publish the result in the cycle the frame-ending vsync edge is detected; o_box_valid SHALL be 1 on the following cycle.
- found = (count >= MIN_PIX).
- If not found, all box outputs SHALL be 0.
REQ-016 SHALL hold o_box_valid and all result outputs stable until a cycle with o_box_valid & i_box_ready; o_box_valid SHALL fall on the next cycle.
REQ-017 SHALL, when a publish occurs while o_box_valid=1 and i_box_ready=0, overwrite the result, keep o_box_valid=1, and set o_overrun. A publish coinciding with a handshake is not an overrun.
REQ-018 SHALL increment o_frame_cnt on every publish.
REQ-019 SHALL NOT discard or clear a held result on a transition to IDLE.

Reset
REQ-020 SHALL, while rst=1 at a pclk edge, set: state IDLE; all outputs 0 (including o_overrun and o_frame_cnt); counters, stop-pending and the vsync history register cleared.
REQ-021 SHALL discard the partial frame and any held result when rst is asserted mid-frame.

Structure
REQ-022 SHALL take its FSM state enum, the X_W/Y_W defaults and the MIN_PIX default from a shared package ot_pkg.
REQ-023 SHALL place the min/max/count accumulation (REQ-013, REQ-014) in a sub-module ot_bbox_acc with clear/update/ready-result ports.

Verification
REQ-024 Bench SHALL cover the single-target case: start; 4x4 frame; hue=30 at (1,2) and (2,3); range 20..40; MIN_PIX=2 -> found=1, box x1..2, y2..3, o_frame_cnt=1.
REQ-025 Bench SHALL cover the wrap-around range: lo=250, hi=5; hues 252 and 3 matched, hue 128 not matched.
REQ-026 Bench SHALL cover the below-threshold case: 1 match with MIN_PIX=2 -> found=0, all box outputs 0.
REQ-027 Bench SHALL cover backpressure: i_box_ready=0 across two frame ends -> second result shown, o_overrun=1, o_box_valid stays 1.
REQ-028 Bench SHALL cover stop mid-frame: i_stop asserted in ACTIVE -> frame is reported, then IDLE and o_pipe_en=0; i_stop with i_start in the same cycle in IDLE -> remains IDLE.
REQ-029 Bench SHALL cover reset mid-frame: rst asserted -> all outputs 0 on the next cycle; no result is published for the aborted frame.
